finished_store_buffer_n: RTL and testbench

Parametrised multi-entry successor to the single-slot finished-store buffer. It sits between the store commit point and data memory. Committed stores (address plus data) are queued in program order and drained to memory one per accepted handshake. Younger loads can forward data from any pending store with a matching address, so they do not read stale memory.

---
 rtl/finished_store_buffer_n.sv | 97 +++++++++
 tb/tb_finished_store_buffer_n.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/finished_store_buffer_n.sv
// Multi-entry finished-store buffer: queues committed stores in program order, drains
// them to memory one per handshake and forwards the youngest matching store to loads.
module finished_store_buffer_n #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 33,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              escreverMEM,
   input  logic [ADDR_W-1:0] enderecoMEM,
   input  logic [DATA_W-1:0] dadoMEM,
   input  logic              escreveMEM,
   output logic [ADDR_W-1:0] enderecoMEM_out,
   output logic [DATA_W-1:0] dadoMEM_out,
   output logic              escreverMEM_out,
   output logic              cheio,
   output logic              vazio,
   output logic [CW-1:0]     ocupacao,
   input  logic [ADDR_W-1:0] enderecoLoad,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_dado
);

   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PW-1:0]     r_rd;
   logic [PW-1:0]     r_wr;
   logic [CW-1:0]     r_count;

   logic              w_pop;
   logic              w_push;
   logic [PW-1:0]     w_age_idx [DEPTH];
   logic [DEPTH-1:0]  w_match;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_dado;

   assign cheio           = (r_count == CW'(DEPTH));
   assign vazio           = (r_count == '0);
   assign escreverMEM_out = !vazio;
   assign ocupacao        = r_count;

   assign w_pop  = escreverMEM_out && escreveMEM;
   // A full buffer still accepts a store when the head leaves in the same cycle.
   assign w_push = escreverMEM && (!cheio || w_pop);

   assign enderecoMEM_out = vazio ? '0 : r_addr[r_rd];
   assign dadoMEM_out     = vazio ? '0 : r_data[r_rd];

   // Slot gi of the age order is the gi-th oldest pending entry, counted from the head.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign w_age_idx[gi] = r_rd + PW'(gi);
      assign w_match[gi]   = (CW'(gi) < r_count) && (r_addr[w_age_idx[gi]] == enderecoLoad);
   end

   // Scan oldest to youngest so the last match (closest to the tail) wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_dado = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_match[k]) begin
            w_fwd_hit  = 1'b1;
            w_fwd_dado = r_data[w_age_idx[k]];
         end
      end
   end

   assign fwd_hit  = w_fwd_hit;
   assign fwd_dado = w_fwd_dado;

   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_addr[r_wr] <= enderecoMEM;
         r_data[r_wr] <= dadoMEM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_pop)  r_rd <= r_rd + PW'(1);
         if (w_push) r_wr <= r_wr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_finished_store_buffer_n.sv
// Directed bench for finished_store_buffer_n (DEPTH=4): fill/drain, full push+pop,
// forwarding priority and visibility, pointer wrap and mid-operation reset.
module tb_finished_store_buffer_n;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 33;
   localparam int CW     = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              escreverMEM;
   logic [ADDR_W-1:0] enderecoMEM;
   logic [DATA_W-1:0] dadoMEM;
   logic              escreveMEM;
   logic [ADDR_W-1:0] enderecoMEM_out;
   logic [DATA_W-1:0] dadoMEM_out;
   logic              escreverMEM_out;
   logic              cheio;
   logic              vazio;
   logic [CW-1:0]     ocupacao;
   logic [ADDR_W-1:0] enderecoLoad;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_dado;

   int checks = 0;
   int errors = 0;

   finished_store_buffer_n #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .escreverMEM     (escreverMEM),
      .enderecoMEM     (enderecoMEM),
      .dadoMEM         (dadoMEM),
      .escreveMEM      (escreveMEM),
      .enderecoMEM_out (enderecoMEM_out),
      .dadoMEM_out     (dadoMEM_out),
      .escreverMEM_out (escreverMEM_out),
      .cheio           (cheio),
      .vazio           (vazio),
      .ocupacao        (ocupacao),
      .enderecoLoad    (enderecoLoad),
      .fwd_hit         (fwd_hit),
      .fwd_dado        (fwd_dado)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change 1 ns after it, outputs are sampled 2 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      escreverMEM  = 1'b0;
      escreveMEM   = 1'b0;
      enderecoMEM  = '0;
      dadoMEM      = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push_only(input int a, input int d);
      escreverMEM = 1'b1;
      escreveMEM  = 1'b0;
      enderecoMEM = ADDR_W'(a);
      dadoMEM     = DATA_W'(d);
      tick();
      escreverMEM = 1'b0;
      $display("push addr=%0d data=%0h ocupacao=%0d", a, d, ocupacao);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      enderecoLoad = '0;
      do_reset();
      settle();
      checks++; if (vazio !== 1'b1) begin errors++; $display("FAIL reset_vazio got %0b want 1", vazio); end
      checks++; if (cheio !== 1'b0) begin errors++; $display("FAIL reset_cheio got %0b want 0", cheio); end
      checks++; if (ocupacao !== 3'd0) begin errors++; $display("FAIL reset_ocupacao got %0d want 0", ocupacao); end
      checks++; if (escreverMEM_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", escreverMEM_out); end
      checks++; if (enderecoMEM_out !== 5'd0 || dadoMEM_out !== 33'd0) begin errors++; $display("FAIL reset_head got %0h/%0h want 0/0", enderecoMEM_out, dadoMEM_out); end
      checks++; if (fwd_hit !== 1'b0 || fwd_dado !== 33'd0) begin errors++; $display("FAIL reset_fwd got %0b/%0h want 0/0", fwd_hit, fwd_dado); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         push_only(i + 1, 'hA + i);
         settle();
         checks++; if (ocupacao !== CW'(i + 1)) begin errors++; $display("FAIL fill_ocupacao got %0d want %0d", ocupacao, i + 1); end
      end
      checks++; if (cheio !== 1'b1) begin errors++; $display("FAIL fill_cheio got %0b want 1", cheio); end
      checks++; if (enderecoMEM_out !== 5'd1 || dadoMEM_out !== 33'hA) begin errors++; $display("FAIL fill_head got %0h/%0h want 1/a", enderecoMEM_out, dadoMEM_out); end
      push_only(5, 'hE);
      settle();
      enderecoLoad = 5'd5;
      settle();
      checks++; if (ocupacao !== 3'd4) begin errors++; $display("FAIL drop_ocupacao got %0d want 4", ocupacao); end
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL drop_fwd got %0b want 0", fwd_hit); end
      escreveMEM = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         $display("pop data=%0h", dadoMEM_out);
         checks++; if (escreverMEM_out !== 1'b1 || dadoMEM_out !== DATA_W'('hA + i)) begin errors++; $display("FAIL drain_data got %0b/%0h want 1/%0h", escreverMEM_out, dadoMEM_out, 'hA + i); end
         tick();
      end
      escreveMEM = 1'b0;
      settle();
      checks++; if (vazio !== 1'b1 || dadoMEM_out !== 33'd0) begin errors++; $display("FAIL drain_empty got %0b/%0h want 1/0", vazio, dadoMEM_out); end
   endtask

   task automatic test_full_push_pop();
      int exp_d [4] = '{'hB, 'hC, 'hD, 'hF};
      for (int i = 0; i < 4; i++) push_only(i + 1, 'hA + i);
      escreverMEM = 1'b1;
      escreveMEM  = 1'b1;
      enderecoMEM = 5'd6;
      dadoMEM     = 33'hF;
      tick();
      escreverMEM = 1'b0;
      escreveMEM  = 1'b0;
      settle();
      checks++; if (ocupacao !== 3'd4 || cheio !== 1'b1) begin errors++; $display("FAIL fullpp_ocupacao got %0d/%0b want 4/1", ocupacao, cheio); end
      escreveMEM = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         $display("pop data=%0h", dadoMEM_out);
         checks++; if (dadoMEM_out !== DATA_W'(exp_d[i])) begin errors++; $display("FAIL fullpp_order got %0h want %0h", dadoMEM_out, exp_d[i]); end
         tick();
      end
      escreveMEM = 1'b0;
      settle();
      checks++; if (vazio !== 1'b1) begin errors++; $display("FAIL fullpp_empty got %0b want 1", vazio); end
   endtask

   task automatic test_forward();
      push_only(7, 'h11);
      push_only(7, 'h22);
      enderecoLoad = 5'd7;
      settle();
      checks++; if (fwd_hit !== 1'b1 || fwd_dado !== 33'h22) begin errors++; $display("FAIL fwd_youngest got %0b/%0h want 1/22", fwd_hit, fwd_dado); end
      enderecoLoad = 5'd9;
      settle();
      checks++; if (fwd_hit !== 1'b0 || fwd_dado !== 33'd0) begin errors++; $display("FAIL fwd_miss got %0b/%0h want 0/0", fwd_hit, fwd_dado); end
      escreverMEM = 1'b1;
      enderecoMEM = 5'd9;
      dadoMEM     = 33'h33;
      settle();
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %0b want 0", fwd_hit); end
      tick();
      escreverMEM = 1'b0;
      settle();
      checks++; if (fwd_hit !== 1'b1 || fwd_dado !== 33'h33) begin errors++; $display("FAIL fwd_next_cycle got %0b/%0h want 1/33", fwd_hit, fwd_dado); end
      // Head (7,0x11) pops this cycle; a load of 7 still sees the younger 0x22.
      escreveMEM   = 1'b1;
      enderecoLoad = 5'd7;
      settle();
      checks++; if (fwd_hit !== 1'b1 || fwd_dado !== 33'h22) begin errors++; $display("FAIL fwd_popping got %0b/%0h want 1/22", fwd_hit, fwd_dado); end
      tick();
      tick();
      escreveMEM = 1'b0;
      settle();
      checks++; if (fwd_hit !== 1'b0 || ocupacao !== 3'd1) begin errors++; $display("FAIL fwd_after_pop got %0b/%0d want 0/1", fwd_hit, ocupacao); end
      enderecoLoad = 5'd9;
      settle();
      checks++; if (fwd_hit !== 1'b1 || fwd_dado !== 33'h33) begin errors++; $display("FAIL fwd_remaining got %0b/%0h want 1/33", fwd_hit, fwd_dado); end
      escreveMEM = 1'b1;
      tick();
      escreveMEM = 1'b0;
   endtask

   task automatic test_wrap();
      push_only(10, 'h40);
      for (int i = 0; i < 10; i++) begin
         escreverMEM = 1'b1;
         escreveMEM  = 1'b1;
         enderecoMEM = ADDR_W'(11 + i);
         dadoMEM     = DATA_W'('h41 + i);
         settle();
         $display("push+pop head=%0h", dadoMEM_out);
         checks++; if (dadoMEM_out !== DATA_W'('h40 + i) || ocupacao !== 3'd1) begin errors++; $display("FAIL wrap_head got %0h/%0d want %0h/1", dadoMEM_out, ocupacao, 'h40 + i); end
         tick();
      end
      escreverMEM = 1'b0;
      settle();
      checks++; if (dadoMEM_out !== 33'h4A || enderecoMEM_out !== 5'd20) begin errors++; $display("FAIL wrap_last got %0h/%0h want 4a/14", dadoMEM_out, enderecoMEM_out); end
      tick();
      escreveMEM = 1'b0;
      settle();
      checks++; if (vazio !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0b want 1", vazio); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) push_only(20 + i, 'h50 + i);
      rst          = 1'b1;
      escreverMEM  = 1'b1;
      escreveMEM   = 1'b1;
      enderecoMEM  = 5'd25;
      dadoMEM      = 33'h77;
      tick();
      rst = 1'b0;
      idle_inputs();
      enderecoLoad = 5'd25;
      settle();
      checks++; if (ocupacao !== 3'd0 || vazio !== 1'b1) begin errors++; $display("FAIL midrst_count got %0d/%0b want 0/1", ocupacao, vazio); end
      checks++; if (escreverMEM_out !== 1'b0 || dadoMEM_out !== 33'd0) begin errors++; $display("FAIL midrst_head got %0b/%0h want 0/0", escreverMEM_out, dadoMEM_out); end
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL midrst_fwd got %0b want 0", fwd_hit); end
      push_only(3, 'h99);
      settle();
      checks++; if (dadoMEM_out !== 33'h99 || ocupacao !== 3'd1) begin errors++; $display("FAIL midrst_after got %0h/%0d want 99/1", dadoMEM_out, ocupacao); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_push_pop();
      test_forward();
      test_wrap();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
